// File: rtl/stim_trig_pkg.sv
// Shared definitions for the stimulation trigger generator.
//   CW_DEFAULT   : default width of the delay/pulse/refractory and event counters
//   stim_state_e : FSM state encoding, also exported on the `state` port
package stim_trig_pkg;

  localparam int unsigned CW_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DELAY   = 2'd1,
    ST_PULSE   = 2'd2,
    ST_REFRACT = 2'd3
  } stim_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk_i   : clock
//   rst_i   : asynchronous active-high reset, clears the count
//   inc_i   : increment request (ignored once the count is all ones)
//   clr_i   : synchronous clear, wins over a simultaneous increment
//   count_o : current count
module sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != {Width{1'b1}})) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/stim_trigger_gen.sv
// Turns the discriminator's stim decision into a timed stimulation trigger:
// onset delay, pulse width and refractory lockout, all counted in sample ticks.
//   dataclk            : system clock
//   reset              : asynchronous active-high reset
//   sample_clk         : sample clock level; each rising edge is one tick
//   stim_req           : discriminator stim flag, sampled on ticks
//   enable             : low forces IDLE on the next dataclk edge
//   delay_samples      : ticks from acceptance to pulse onset
//   pulse_samples      : pulse width in ticks (0 acts as 1)
//   refractory_samples : lockout ticks after the pulse
//   counts_clear       : synchronous clear of both event counters
//   stim_out           : stimulation TTL (state PULSE)
//   blank_out, busy    : state is not IDLE
//   stim_count         : delivered pulses, saturating
//   missed_count       : requests seen while not IDLE, saturating
//   state              : current FSM state
module stim_trigger_gen
  import stim_trig_pkg::*;
#(
  parameter int unsigned CW = CW_DEFAULT
) (
  input  logic          dataclk,
  input  logic          reset,
  input  logic          sample_clk,
  input  logic          stim_req,
  input  logic          enable,
  input  logic [CW-1:0] delay_samples,
  input  logic [CW-1:0] pulse_samples,
  input  logic [CW-1:0] refractory_samples,
  input  logic          counts_clear,
  output logic          stim_out,
  output logic          blank_out,
  output logic          busy,
  output logic [CW-1:0] stim_count,
  output logic [CW-1:0] missed_count,
  output logic [1:0]    state
);

  localparam logic [CW-1:0] One = CW'(1);

  stim_state_e   state_q, state_d;
  logic          sclk_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] pulse_q, pulse_d;
  logic [CW-1:0] refr_q, refr_d;
  logic          tick;
  logic          stim_inc;
  logic          missed_inc;

  assign tick = sample_clk & ~sclk_q;

  // max(p,1)-1: a zero width still produces a one-tick pulse
  function automatic logic [CW-1:0] pulse_load(input logic [CW-1:0] p);
    return (p == '0) ? '0 : p - One;
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pulse_d    = pulse_q;
    refr_d     = refr_q;
    stim_inc   = 1'b0;
    missed_inc = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
    end else if (tick) begin
      missed_inc = stim_req && (state_q != ST_IDLE);
      case (state_q)
        ST_IDLE: begin
          if (stim_req) begin
            // Pulse/refractory are held for the whole event; delay is consumed now
            pulse_d = pulse_samples;
            refr_d  = refractory_samples;
            if (delay_samples != '0) begin
              state_d = ST_DELAY;
              cnt_d   = delay_samples - One;
            end else begin
              state_d  = ST_PULSE;
              cnt_d    = pulse_load(pulse_samples);
              stim_inc = 1'b1;
            end
          end
        end
        ST_DELAY: begin
          if (cnt_q == '0) begin
            state_d  = ST_PULSE;
            cnt_d    = pulse_load(pulse_q);
            stim_inc = 1'b1;
          end else begin
            cnt_d = cnt_q - One;
          end
        end
        ST_PULSE: begin
          if (cnt_q == '0) begin
            if (refr_q != '0) begin
              state_d = ST_REFRACT;
              cnt_d   = refr_q - One;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            cnt_d = cnt_q - One;
          end
        end
        ST_REFRACT: begin
          if (cnt_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - One;
          end
        end
      endcase
    end
  end

  always_ff @(posedge dataclk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sclk_q  <= 1'b0;
      cnt_q   <= '0;
      pulse_q <= '0;
      refr_q  <= '0;
    end else begin
      state_q <= state_d;
      sclk_q  <= sample_clk;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      refr_q  <= refr_d;
    end
  end

  sat_counter #(
    .Width (CW)
  ) u_stim_cnt (
    .clk_i   (dataclk),
    .rst_i   (reset),
    .inc_i   (stim_inc),
    .clr_i   (counts_clear),
    .count_o (stim_count)
  );

  sat_counter #(
    .Width (CW)
  ) u_missed_cnt (
    .clk_i   (dataclk),
    .rst_i   (reset),
    .inc_i   (missed_inc),
    .clr_i   (counts_clear),
    .count_o (missed_count)
  );

  // Outputs decode only registered state
  assign stim_out  = (state_q == ST_PULSE);
  assign blank_out = (state_q != ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign state     = state_q;

endmodule
